es_mul_seq: RTL and testbench
=============================

ES_MUL_SEQ -- requirements
Module: es_mul_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, width of each binary operand.
REQ-002 SHALL have parameter NUM_INPUTS, default 2, number of operands per multiply.
REQ-003 SHALL have parameter RES_WIDTH, default DATA_WIDTH*NUM_INPUTS, width of product from multiplier.
REQ-004 SHALL have parameter CYC_WIDTH, default RES_WIDTH+1, width of run-cycle counter.
REQ-005 SHALL have parameter TIMEOUT, default 2**RES_WIDTH+2, watchdog limit in RUN cycles.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  operand bundle valid.
REQ-009 in_ready  output  1  sequencer can accept operands.
REQ-010 in_data  input  NUM_INPUTS*DATA_WIDTH  operand i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 mul_rst  output  1  reset pulse to downstream stochastic multiplier.
REQ-012 mul_en  output  1  enable to multiplier.
REQ-013 mul_data  output  NUM_INPUTS*DATA_WIDTH  registered operands, held stable for whole run.
REQ-014 mul_result  input  RES_WIDTH  multiplier counter value.
REQ-015 mul_done  input  1  multiplier completion flag (may be combinational, may glitch high early).
REQ-016 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-017 out_data  output  RES_WIDTH  captured product.
REQ-018 out_cycles  output  CYC_WIDTH  RUN cycles consumed, saturating at all-ones.
REQ-019 out_err  output  1  watchdog abort flag accompanying out_data.

Function
REQ-020 SHALL implement FSM states IDLE, CLR, RUN, CAP, OUT.
REQ-021 IDLE: in_ready=1; on in_valid&in_ready latch in_data into mul_data, clear cycle counter, go CLR.
REQ-022 CLR: mul_rst=1 for exactly one cycle, mul_en=0, then RUN.
REQ-023 RUN: mul_en=1, mul_rst=0, cycle counter +1 per cycle (saturating).
REQ-024 RUN: mul_done SHALL be ignored in the first RUN cycle; from second RUN cycle, mul_done=1 sampled -> CAP.
REQ-025 CAP: mul_en=0; register mul_result into out_data and counter into out_cycles; go OUT next cycle.
REQ-026 OUT: out_valid=1; out_data/out_cycles/out_err stable until out_valid&out_ready, then IDLE.
REQ-027 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE is ignored and not lost by sequencer (source holds).
REQ-028 Operand acceptance to out_valid latency SHALL be N+3 cycles, N = RUN cycles.
REQ-029 mul_data SHALL not change between acceptance and return to IDLE.
REQ-030 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-031 rst=1 SHALL force IDLE from any state, including mid-RUN, on next edge.
REQ-032 Reset values: in_ready=1 after release, mul_rst=1 while rst high, mul_en=0, mul_data=0, out_valid=0, out_data=0, out_cycles=0, out_err=0.
REQ-033 Abort by rst SHALL discard any in-flight operands and produce no output.

Configuration
REQ-034 Macro ES_MUL_SEQ_TIMEOUT_EN: when defined, if counter reaches TIMEOUT in RUN without mul_done, go CAP with out_err=1; out_data captures mul_result as is.
REQ-035 Without ES_MUL_SEQ_TIMEOUT_EN: no watchdog logic, out_err tied 0, RUN waits indefinitely for mul_done.

Verification
REQ-036 Operands 16,16; mul_done rises 32 RUN cycles later with mul_result=8 -> out_data=8, out_cycles=32, out_valid 35 cycles after accept.
REQ-037 mul_done=1 in first RUN cycle, then 0, then 1 at cycle 5 -> capture at cycle 5, out_cycles=5.
REQ-038 out_ready held 0 for 10 cycles in OUT -> out_valid/out_data stable, in_ready=0, new in_valid ignored.
REQ-039 rst pulsed at RUN cycle 7 -> IDLE next edge, mul_en=0, out_valid never asserted, next operand accepted normally.
REQ-040 TIMEOUT_EN defined, TIMEOUT=20, mul_done held 0 -> out_err=1, out_cycles=20; macro undefined -> no output after 1000 cycles.

Source files
------------

// File: rtl/es_mul_seq.sv
`timescale 1ns/1ps
// es_mul_seq: sequencer around a stochastic multiplier.
// Accepts an operand bundle, pulses the multiplier reset, enables it until it
// reports done, then captures the product and the RUN cycle count.
// Optional watchdog: define ES_MUL_SEQ_TIMEOUT_EN to abort RUN after TIMEOUT
// cycles and flag the result with out_err.
module es_mul_seq #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned RES_WIDTH  = DATA_WIDTH*NUM_INPUTS,
  parameter int unsigned CYC_WIDTH  = RES_WIDTH+1,
  parameter int unsigned TIMEOUT    = 2**RES_WIDTH+2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic                             mul_rst,
  output logic                             mul_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_data,
  input  logic [RES_WIDTH-1:0]             mul_result,
  input  logic                             mul_done,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [RES_WIDTH-1:0]             out_data,
  output logic [CYC_WIDTH-1:0]             out_cycles,
  output logic                             out_err
);

  localparam int unsigned IN_WIDTH = NUM_INPUTS*DATA_WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [CYC_WIDTH-1:0] cnt_q;
  logic [CYC_WIDTH-1:0] cnt_d;
  logic [CYC_WIDTH-1:0] cnt_inc;
  logic [IN_WIDTH-1:0]  mul_data_d;
  logic [RES_WIDTH-1:0] out_data_d;
  logic [CYC_WIDTH-1:0] out_cycles_d;

`ifdef ES_MUL_SEQ_TIMEOUT_EN
  localparam logic [CYC_WIDTH-1:0] TO_LIM = CYC_WIDTH'(TIMEOUT);
  logic tout_q;
  logic tout_d;
  logic out_err_d;
`else
  // The watchdog limit has no consumer in this build.
  logic unused_timeout;
  assign unused_timeout = ^CYC_WIDTH'(TIMEOUT);
`endif

  // Saturating increment of the RUN cycle counter.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CYC_WIDTH'(1);

  // Next-state and next-datapath logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_data_d   = mul_data;
    out_data_d   = out_data;
    out_cycles_d = out_cycles;
`ifdef ES_MUL_SEQ_TIMEOUT_EN
    tout_d       = tout_q;
    out_err_d    = out_err;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          mul_data_d = in_data;
          cnt_d      = '0;
`ifdef ES_MUL_SEQ_TIMEOUT_EN
          tout_d     = 1'b0;
`endif
          state_d    = S_CLR;
        end
      end
      S_CLR: state_d = S_RUN;
      S_RUN: begin
        cnt_d = cnt_inc;
        // cnt_q is zero only in the first RUN cycle, where mul_done may glitch.
        if (mul_done && (cnt_q != '0)) begin
          state_d = S_CAP;
        end
`ifdef ES_MUL_SEQ_TIMEOUT_EN
        else if (cnt_inc >= TO_LIM) begin
          state_d = S_CAP;
          tout_d  = 1'b1;
        end
`endif
      end
      S_CAP: begin
        out_data_d   = mul_result;
        out_cycles_d = cnt_q;
`ifdef ES_MUL_SEQ_TIMEOUT_EN
        out_err_d    = tout_q;
`endif
        state_d      = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered state-decoded control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      in_ready   <= 1'b1;
      mul_rst    <= 1'b1;
      mul_en     <= 1'b0;
      out_valid  <= 1'b0;
      mul_data   <= '0;
      out_data   <= '0;
      out_cycles <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready   <= (state_d == S_IDLE);
      mul_rst    <= (state_d == S_CLR);
      mul_en     <= (state_d == S_RUN);
      out_valid  <= (state_d == S_OUT);
      mul_data   <= mul_data_d;
      out_data   <= out_data_d;
      out_cycles <= out_cycles_d;
    end
  end

`ifdef ES_MUL_SEQ_TIMEOUT_EN
  // Watchdog flag for the current run and the error flag shown with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      tout_q  <= 1'b0;
      out_err <= 1'b0;
    end else begin
      tout_q  <= tout_d;
      out_err <= out_err_d;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_es_mul_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for es_mul_seq with a behavioural multiplier stub.
module tb_es_mul_seq;
  localparam int unsigned DW = 5;
  localparam int unsigned NI = 2;
  localparam int unsigned IW = DW*NI;
  localparam int unsigned RW = DW*NI;
  localparam int unsigned CW = RW+1;
  localparam int unsigned TO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          mul_rst;
  logic          mul_en;
  logic [IW-1:0] mul_data;
  logic [RW-1:0] mul_result = '0;
  logic          mul_done = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic [CW-1:0] out_cycles;
  logic          out_err;

  es_mul_seq #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .RES_WIDTH(RW), .CYC_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_data(mul_data), .mul_result(mul_result),
    .mul_done(mul_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cycles(out_cycles), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IW-1:0] data;
    logic [RW-1:0] res;
    int unsigned   n;
    bit            err;
    int unsigned   acc;
    int unsigned   hold;
  } exp_t;

  typedef struct {
    int unsigned   tgt;
    bit            glitch;
    logic [RW-1:0] res;
  } mul_t;

  exp_t sb[$];
  mul_t stub_q[$];
  mul_t cur = '{0, 1'b0, '0};
  int unsigned run_k = 0;
  logic [IW-1:0] inflight = '0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Multiplier stub: counts enabled cycles since its reset, raises done at the
  // target count (optionally glitching in run cycle 1), result valid from then on.
  always @(negedge clk) begin
    if (mul_rst) begin
      run_k = 0;
      if (stub_q.size() > 0) cur = stub_q.pop_front();
    end else if (mul_en) begin
      run_k = run_k + 1;
    end
    mul_done   = ((cur.tgt != 0) && (run_k >= cur.tgt)) || (cur.glitch && (run_k == 1));
    mul_result = ((cur.tgt == 0) || (run_k >= cur.tgt)) ? cur.res : RW'($urandom);
  end

  // Monitor: operand stability while busy, result checking and out_ready policy.
  bit            seen = 1'b0;
  int unsigned   hold_left = 0;
  exp_t          em;
  logic [RW-1:0] snap_data;
  logic [CW-1:0] snap_cyc;
  logic          snap_err;

  always @(negedge clk) begin
    if (rst === 1'b0 && in_ready === 1'b0)
      check("mul_data_hold", 64'(mul_data), 64'(inflight));
    if (rst) begin
      seen      = 1'b0;
      out_ready = 1'b0;
    end else if (out_valid === 1'b1) begin
      if (!seen) begin
        seen = 1'b1;
        hold_left = 0;
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(out_valid), 64'(0));
        end else begin
          em = sb.pop_front();
          check("out_data",   64'(out_data),   64'(em.res));
          check("out_cycles", 64'(out_cycles), 64'(em.n));
          check("out_err",    64'(out_err),    64'(em.err));
          check("latency",    64'(cyc - em.acc), 64'(em.n + 3));
          hold_left = em.hold;
        end
        snap_data = out_data;
        snap_cyc  = out_cycles;
        snap_err  = out_err;
      end else begin
        check("out_data_stable",   64'(out_data),   64'(snap_data));
        check("out_cycles_stable", 64'(out_cycles), 64'(snap_cyc));
        check("out_err_stable",    64'(out_err),    64'(snap_err));
        check("in_ready_in_out",   64'(in_ready),   64'(0));
      end
      if (hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else begin
        out_ready = 1'b1;
      end
    end else begin
      seen      = 1'b0;
      out_ready = 1'($urandom % 2);
    end
  end

  // Present one operand bundle from a negedge and hold it until accepted.
  task automatic issue(input logic [IW-1:0] d, input int unsigned tgt, input bit gl,
                       input logic [RW-1:0] res, input int unsigned hold,
                       input bit expect_out, input bit err);
    exp_t e;
    mul_t m;
    int unsigned w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      w++;
      if (w > 3000) begin
        check("accept_wait", 64'(in_ready), 64'(1));
        in_valid = 1'b0;
        return;
      end
    end
    m.tgt = tgt; m.glitch = gl; m.res = res;
    stub_q.push_back(m);
    inflight = d;
    if (expect_out) begin
      e.data = d; e.res = res; e.n = err ? TO : tgt; e.err = err;
      e.acc = cyc; e.hold = hold;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = IW'($urandom);
  endtask

  task automatic drain();
    int unsigned w;
    w = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1 || out_valid !== 1'b0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    exp_t dropped;
    int unsigned k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",   64'(in_ready),   64'(1));
    check("rst_mul_rst",    64'(mul_rst),    64'(1));
    check("rst_mul_en",     64'(mul_en),     64'(0));
    check("rst_mul_data",   64'(mul_data),   64'(0));
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_out_data",   64'(out_data),   64'(0));
    check("rst_out_cycles", 64'(out_cycles), 64'(0));
    check("rst_out_err",    64'(out_err),    64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'(1));
    check("idle_mul_rst",  64'(mul_rst),  64'(0));

    // Operands 16,16; done after 32 RUN cycles with result 8.
    issue({5'd16, 5'd16}, 32, 1'b0, RW'(8), 0, 1'b1, 1'b0);
    // Early glitch in RUN cycle 1, real done at cycle 5.
    issue(IW'($urandom), 5, 1'b1, RW'($urandom), 0, 1'b1, 1'b0);
    // Consumer stalls 10 cycles; next bundle is already waiting.
    issue(IW'($urandom), 6, 1'b0, RW'($urandom), 10, 1'b1, 1'b0);
    issue(IW'($urandom), 3, 1'b0, RW'($urandom), 0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      issue(IW'($urandom), $urandom_range(40, 2), 1'($urandom % 2), RW'($urandom),
            $urandom_range(3, 0), 1'b1, 1'b0);
    end
    drain();

    // Abort with reset in RUN cycle 7.
    issue(IW'($urandom), 50, 1'b0, RW'($urandom), 0, 1'b1, 1'b0);
    k = 0;
    for (int i = 0; i < 200 && k < 7; i++) begin
      @(negedge clk);
      if (mul_en) k++;
    end
    check("abort_run_cycle", 64'(k), 64'(7));
    rst = 1'b1;
    if (sb.size() > 0) dropped = sb.pop_back();
    @(negedge clk);
    rst = 1'b0;
    check("abort_mul_en",    64'(mul_en),    64'(0));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_mul_data",  64'(mul_data),  64'(0));
    check("abort_mul_rst",   64'(mul_rst),   64'(1));
    @(negedge clk);
    check("post_abort_in_ready", 64'(in_ready), 64'(1));
    check("post_abort_mul_rst",  64'(mul_rst),  64'(0));
    issue(IW'($urandom), 9, 1'b1, RW'($urandom), 1, 1'b1, 1'b0);
    drain();

`ifdef ES_MUL_SEQ_TIMEOUT_EN
    // Done never arrives: watchdog captures after TO RUN cycles with the error flag.
    issue(IW'($urandom), 0, 1'b0, RW'($urandom), 2, 1'b1, 1'b1);
    drain();
    issue(IW'($urandom), 4, 1'b0, RW'($urandom), 0, 1'b1, 1'b0);
    drain();
`else
    // Done never arrives: sequencer keeps running with no output.
    issue(IW'($urandom), 0, 1'b0, RW'($urandom), 0, 1'b0, 1'b0);
    repeat (1000) @(negedge clk);
    check("no_timeout_out_valid", 64'(out_valid), 64'(0));
    check("no_timeout_mul_en",    64'(mul_en),    64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("no_timeout_recover", 64'(in_ready), 64'(1));
    issue(IW'($urandom), 4, 1'b0, RW'($urandom), 0, 1'b1, 1'b0);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
